alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width, power of two, minimum 8.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(DATA_WIDTH): shift-amount width; not overridden.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operation request present.
REQ-006 SHALL have port in_ready, output, 1: block can accept a request.
REQ-007 SHALL have port ALUop1, input, DATA_WIDTH: first operand.
REQ-008 SHALL have port ALUop2, input, DATA_WIDTH: second operand; the low SHAMT_W bits are the shift amount.
REQ-009 SHALL have port ALUctrl, input, 4: operation select.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port ALUout, output, DATA_WIDTH: registered result.
REQ-013 SHALL have port EQ, output, 1: registered, 1 when ALUout is all zeros.
REQ-014 SHALL have port ERR, output, 1: registered, 1 when the accepted operation was unsupported.

Function
REQ-015 ALUctrl encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (signed), 0101 XOR, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 MUL (low DATA_WIDTH bits of the product); 1011-1111 give the ADD result with ERR=1.
REQ-016 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; SLT/SLTU SHALL return zero-extended 1 when ALUop1 < ALUop2 and 0 otherwise.
REQ-017 The FSM SHALL have states IDLE, SHIFT, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on the clk edge where in_valid && in_ready; operands and ALUctrl SHALL be captured then, and later input changes ignored.
REQ-019 ADD/SUB/AND/OR/XOR/SLT/SLTU/reserved codes: IDLE->DONE, out_valid asserted 1 cycle after acceptance.
REQ-020 SLL/SRL/SRA SHALL shift one bit per cycle in SHIFT: IDLE->SHIFT for shamt cycles, then DONE (latency shamt+1); shamt=0 SHALL go IDLE->DONE with the operand unchanged.
REQ-021 SRA SHALL replicate the sign bit; SRL/SLL SHALL insert zeros.
REQ-022 MUL SHALL use iterative shift-add in MUL for exactly DATA_WIDTH cycles, then DONE (latency DATA_WIDTH+1).
REQ-023 In DONE, out_valid=1 and ALUout/EQ/ERR SHALL be held stable until out_valid && out_ready; on that edge the FSM SHALL go to IDLE.
REQ-024 No new request SHALL be accepted in the cycle the result is consumed; the earliest next acceptance is one cycle later (1 result per 2 cycles max for single-cycle ops).
REQ-025 EQ SHALL be computed from the final result only and SHALL be valid whenever out_valid=1.

Reset
REQ-026 On rst=1, regardless of clk, the FSM SHALL go to IDLE and out_valid, ALUout, EQ, ERR SHALL be 0; in_ready SHALL be 1 once rst deasserts.
REQ-027 Reset during SHIFT, MUL or DONE SHALL abort the operation, discarding any pending result.

Configuration
REQ-028 Macro ALU_MC_MUL_EN defined: MUL SHALL behave per REQ-022.
REQ-029 ALU_MC_MUL_EN undefined: no multiplier logic and no MUL state SHALL exist; code 1010 SHALL be treated as reserved (ADD result, ERR=1, latency 1).

Verification
REQ-030 ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> out_valid 1 cycle after acceptance, ALUout=0x80000000, EQ=0, ERR=0.
REQ-031 SUB 5-5 -> ALUout=0, EQ=1; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
REQ-032 SRA 0x80000000 by 4 -> ALUout=0xF8000000 after exactly 5 cycles, in_ready=0 throughout; SLL by 0 -> latency 1, operand unchanged.
REQ-033 MUL 0x0001_0003 x 0x0000_0005 (macro defined) -> 0x0005_000F after 33 cycles; macro undefined -> ADD result 0x0001_0008, ERR=1 after 1 cycle.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while toggling inputs -> ALUout/EQ/ERR stable, in_ready=0; accept on out_ready=1, IDLE next cycle.
REQ-035 Assert rst mid-MUL at cycle 12 -> out_valid, ALUout, EQ, ERR =0 immediately; after release, next ADD completes correctly.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic ops, bit-serial shifts,
// and an optional shift-add multiplier enabled by defining ALU_MC_MUL_EN.
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [3:0]            ALUctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  ERR
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_MC_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  eq_q, eq_d;
  logic                  err_q, err_d;
`ifdef ALU_MC_MUL_EN
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] acc_step;
`endif

  logic [SHAMT_W-1:0]    shamt;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] fast_res;
  logic                  fast_err;
  logic [DATA_WIDTH-1:0] shift_step;

  assign shamt    = ALUop2[SHAMT_W-1:0];
  assign is_shift = (ALUctrl == 4'b0110) || (ALUctrl == 4'b0111) || (ALUctrl == 4'b1000);

  // Result for everything finishing straight out of IDLE (shift by zero passes op1 through).
  always_comb begin
    fast_res = ALUop1 + ALUop2;
    fast_err = 1'b0;
    case (ALUctrl)
      4'b0000: fast_res = ALUop1 + ALUop2;
      4'b0001: fast_res = ALUop1 - ALUop2;
      4'b0010: fast_res = ALUop1 & ALUop2;
      4'b0011: fast_res = ALUop1 | ALUop2;
      4'b0100: fast_res = DATA_WIDTH'($signed(ALUop1) < $signed(ALUop2));
      4'b0101: fast_res = ALUop1 ^ ALUop2;
      4'b0110, 4'b0111, 4'b1000: fast_res = ALUop1;
      4'b1001: fast_res = DATA_WIDTH'(ALUop1 < ALUop2);
      default: fast_err = 1'b1;
    endcase
  end

  always_comb begin
    case (ctrl_q)
      4'b0111: shift_step = {1'b0, a_q[DATA_WIDTH-1:1]};
      4'b1000: shift_step = {a_q[DATA_WIDTH-1], a_q[DATA_WIDTH-1:1]};
      default: shift_step = {a_q[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

`ifdef ALU_MC_MUL_EN
  assign acc_step = acc_q + (b_q[0] ? a_q : '0);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    eq_d    = eq_q;
    err_d   = err_q;
`ifdef ALU_MC_MUL_EN
    b_d     = b_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ctrl_d = ALUctrl;
          a_d    = ALUop1;
          if (is_shift && (shamt != '0)) begin
            cnt_d   = CNT_W'(shamt);
            state_d = SHIFT;
`ifdef ALU_MC_MUL_EN
          end else if (ALUctrl == 4'b1010) begin
            b_d     = ALUop2;
            acc_d   = '0;
            cnt_d   = CNT_W'(DATA_WIDTH);
            state_d = MUL;
`endif
          end else begin
            res_d   = fast_res;
            eq_d    = (fast_res == '0);
            err_d   = fast_err;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        a_d   = shift_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          res_d   = shift_step;
          eq_d    = (shift_step == '0);
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
`ifdef ALU_MC_MUL_EN
      MUL: begin
        acc_d = acc_step;
        a_d   = {a_q[DATA_WIDTH-2:0], 1'b0};
        b_d   = {1'b0, b_q[DATA_WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          res_d   = acc_step;
          eq_d    = (acc_step == '0);
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MC_MUL_EN
      b_q     <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
`ifdef ALU_MC_MUL_EN
      b_q     <= b_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUout    = res_q;
  assign EQ        = eq_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] ALUop1 = '0;
  logic [W-1:0] ALUop2 = '0;
  logic [3:0]   ALUctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] ALUout;
  logic         EQ;
  logic         ERR;

  int checks = 0;
  int errors = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUout(ALUout), .EQ(EQ), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    e   = 1'b0;
    lat = 1;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: begin r = a << sh; lat = sh + 1; end
      4'd7: begin r = a >> sh; lat = sh + 1; end
      4'd8: begin r = $unsigned($signed(a) >>> sh); lat = sh + 1; end
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MC_MUL_EN
      4'd10: begin r = a * b; lat = W + 1; end
`endif
      default: begin r = a + b; e = 1'b1; end
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] er;
    logic         ee;
    int           elat;
    int           lat;
    int           n;
    model(c, a, b, er, ee, elat);
    @(negedge clk);
    in_valid = 1'b1; ALUop1 = a; ALUop2 = b; ALUctrl = c; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ALUop1 = $urandom; ALUop2 = $urandom; ALUctrl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_res"}, 64'(ALUout), 64'(er));
    check({tag, "_eq"},  64'(EQ), 64'(er == '0));
    check({tag, "_err"}, 64'(ERR), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); ALUop1 = $urandom; ALUop2 = $urandom; ALUctrl = 4'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_res"}, {31'd0, out_valid, ERR, EQ, ALUout}, {31'd0, 1'b1, ee, er == '0, er});
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    $display("op %s ctrl=%0d a=%h b=%h res=%h lat=%0d", tag, c, a, b, ALUout, lat);
  endtask

  initial begin
    logic [3:0] lc;
    logic [W-1:0] lb;
    #1 rst = 1'b1;
    #1;
    check("rst_outs", {in_ready, out_valid, ERR, EQ, ALUout}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("rst_ready", 64'(in_ready), 64'd1);

    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
    run_op(4'd1, 32'd5, 32'd5, 0, "sub_zero");
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
    run_op(4'd8, 32'h8000_0000, 32'd4, 0, "sra4");
    run_op(4'd6, 32'h1234_5678, 32'd0, 0, "sll0");
    run_op(4'd7, 32'h8000_0001, 32'd31, 1, "srl31");
    run_op(4'd10, 32'h0001_0003, 32'h0000_0005, 0, "mul");
    run_op(4'd15, 32'd3, 32'd4, 0, "resv");
    run_op(4'd5, 32'hA5A5_0F0F, 32'hFFFF_0000, 10, "hold10");

    // Abort a long operation with an asynchronous reset in the middle of a cycle.
`ifdef ALU_MC_MUL_EN
    lc = 4'd10; lb = 32'h0000_0005;
`else
    lc = 4'd6;  lb = 32'd31;
`endif
    @(negedge clk);
    in_valid = 1'b1; ALUop1 = 32'h0001_0003; ALUop2 = lb; ALUctrl = lc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("midrst_outs", {out_valid, ERR, EQ, ALUout}, {1'b0, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready", 64'(in_ready), 64'd1);
    run_op(4'd0, 32'h0000_1111, 32'h0000_2222, 0, "post_rst_add");

    for (int k = 0; k < 150; k++) begin
      lc = 4'($urandom_range(0, 15));
      run_op(lc, $urandom, $urandom, int'($urandom_range(0, 2)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
